tcp_tuple_extractor_q: RTL

//  Next-generation TCP flow-tuple extractor for the user datapath. Forwards every packet word

---
 rtl/tcp_tuple_extractor_q.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tcp_tuple_extractor_q.sv
// rtl/tcp_tuple_extractor_q.sv - cut-through TCP flow-tuple extractor with a descriptor queue
// Words pass unchanged through a fallthrough FIFO; the header parser never backpressures the datapath.
module tcp_tuple_extractor_q #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = 8,
    parameter int TUPLE_SZ        = 96,
    parameter int DESC_DEPTH_BITS = 2,
    parameter int IN_FIFO_BITS    = 3,
    parameter int CNT_WIDTH       = 32,
    parameter int NORM_MODE       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  bloom_rdy,
    output logic                  bloom_wr,
    output logic [TUPLE_SZ-1:0]   tuple,
    output logic [8:0]            tcp_flags,
    output logic [CNT_WIDTH-1:0]  num_tcp,
    output logic [CNT_WIDTH-1:0]  num_desc_drop,
    output logic [CNT_WIDTH-1:0]  num_short
);

    localparam int IW         = CTRL_WIDTH + DATA_WIDTH;
    localparam int DW         = TUPLE_SZ + 9;
    localparam int IN_DEPTH   = 1 << IN_FIFO_BITS;
    localparam int DESC_DEPTH = 1 << DESC_DEPTH_BITS;

    typedef enum logic [6:0] {
        S_IDLE = 7'b0000001,
        S_W2   = 7'b0000010,
        S_W3   = 7'b0000100,
        S_W4   = 7'b0001000,
        S_W5   = 7'b0010000,
        S_W6   = 7'b0100000,
        S_SKIP = 7'b1000000
    } state_t;

    logic [IW-1:0]         in_mem [IN_DEPTH];
    logic [IN_FIFO_BITS:0] in_wptr, in_rptr;
    logic                  in_fifo_empty, in_fifo_full, in_fifo_wr_en, in_fifo_rd_en;

    assign in_fifo_empty = (in_wptr == in_rptr);
    assign in_fifo_full  = (in_wptr[IN_FIFO_BITS] != in_rptr[IN_FIFO_BITS]) &&
                           (in_wptr[IN_FIFO_BITS-1:0] == in_rptr[IN_FIFO_BITS-1:0]);
    assign in_rdy        = !in_fifo_full;
    assign in_fifo_wr_en = in_wr && !in_fifo_full;
    assign in_fifo_rd_en = !in_fifo_empty && out_rdy;
    assign out_wr        = in_fifo_rd_en;
    assign {out_ctrl, out_data} = in_mem[in_rptr[IN_FIFO_BITS-1:0]];

    always_ff @(posedge clk) begin
        if (in_fifo_wr_en)
            in_mem[in_wptr[IN_FIFO_BITS-1:0]] <= {in_ctrl, in_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_wptr <= '0;
            in_rptr <= '0;
        end else begin
            if (in_fifo_wr_en) in_wptr <= in_wptr + 1'b1;
            if (in_fifo_rd_en) in_rptr <= in_rptr + 1'b1;
        end
    end

    state_t      state;
    logic [31:0] srcip, dstip;
    logic [15:0] sport, dport;
    logic        eop, in_hdr, push, tcp_inc, short_inc;

    assign eop       = |out_ctrl;
    assign in_hdr    = (state == S_W2) || (state == S_W3) || (state == S_W4) ||
                       (state == S_W5) || (state == S_W6);
    assign push      = in_fifo_rd_en && (state == S_W6) && !eop;
    assign tcp_inc   = in_fifo_rd_en && (state == S_W3) && !eop && (out_data[7:0] == 8'h06);
    assign short_inc = in_fifo_rd_en && in_hdr && eop;

    // Parser only advances on words that actually leave the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            srcip <= '0;
            dstip <= '0;
            sport <= '0;
            dport <= '0;
        end else if (in_fifo_rd_en) begin
            case (state)
                S_IDLE: if (!eop) state <= S_W2;
                S_W2: begin
                    if (eop)
                        state <= S_IDLE;
                    else if (out_data[31:16] == 16'h0800 && out_data[15:8] == 8'h45)
                        state <= S_W3;
                    else
                        state <= S_SKIP;
                end
                S_W3: begin
                    if (eop)                         state <= S_IDLE;
                    else if (out_data[7:0] == 8'h06) state <= S_W4;
                    else                             state <= S_SKIP;
                end
                S_W4: begin
                    if (eop) begin
                        state <= S_IDLE;
                    end else begin
                        srcip        <= out_data[47:16];
                        dstip[31:16] <= out_data[15:0];
                        state        <= S_W5;
                    end
                end
                S_W5: begin
                    if (eop) begin
                        state <= S_IDLE;
                    end else begin
                        dstip[15:0] <= out_data[63:48];
                        sport       <= out_data[47:32];
                        dport       <= out_data[31:16];
                        state       <= S_W6;
                    end
                end
                S_W6:    state <= eop ? S_IDLE : S_SKIP;
                S_SKIP:  if (eop) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic swap;
    logic [DW-1:0] new_desc;

    always_comb begin
        swap = 1'b0;
        if (NORM_MODE == 0)
            swap = out_data[4];
        else
            swap = ({dstip, dport} < {srcip, sport});
    end

    assign new_desc = swap ? {dstip, srcip, dport, sport, out_data[8:0]}
                           : {srcip, dstip, sport, dport, out_data[8:0]};

    logic [DW-1:0]            dq_mem [DESC_DEPTH];
    logic [DESC_DEPTH_BITS:0] dq_wptr, dq_rptr;
    logic                     dq_empty, dq_full, dq_pop, dq_push, drop_inc;

    assign dq_empty = (dq_wptr == dq_rptr);
    assign dq_full  = (dq_wptr[DESC_DEPTH_BITS] != dq_rptr[DESC_DEPTH_BITS]) &&
                      (dq_wptr[DESC_DEPTH_BITS-1:0] == dq_rptr[DESC_DEPTH_BITS-1:0]);
    assign dq_pop   = !dq_empty && bloom_rdy;
    // A pop in the same cycle frees the slot the push lands in.
    assign dq_push  = push && (!dq_full || dq_pop);
    assign drop_inc = push && dq_full && !dq_pop;
    assign bloom_wr = dq_pop;
    assign {tuple, tcp_flags} = dq_empty ? '0 : dq_mem[dq_rptr[DESC_DEPTH_BITS-1:0]];

    always_ff @(posedge clk) begin
        if (dq_push)
            dq_mem[dq_wptr[DESC_DEPTH_BITS-1:0]] <= new_desc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dq_wptr       <= '0;
            dq_rptr       <= '0;
            num_tcp       <= '0;
            num_desc_drop <= '0;
            num_short     <= '0;
        end else begin
            if (dq_push) dq_wptr <= dq_wptr + 1'b1;
            if (dq_pop)  dq_rptr <= dq_rptr + 1'b1;
            if (tcp_inc && num_tcp != '1)         num_tcp       <= num_tcp + 1'b1;
            if (drop_inc && num_desc_drop != '1)  num_desc_drop <= num_desc_drop + 1'b1;
            if (short_inc && num_short != '1)     num_short     <= num_short + 1'b1;
        end
    end

endmodule
